seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the CPU core. Owns the program counter and steps each instruction through fetch, execute and, for loads/stores, a data-memory handshake. Converts the level-valued decode outputs (RegWrite, MemWrite, LdStSel, BranchRel) into single-cycle commit strobes. Reports completion and a cycle count to the testbench.

---
 rtl/seq_ctrl_pkg.sv | 27 ++
 rtl/seq_ctrl_pc_unit.sv | 61 ++++++
 rtl/seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared definitions for the multi-cycle instruction sequencer: the sequencer
// state encoding, the cycle-counter ceiling and a saturating increment helper.
// -----------------------------------------------------------------------------
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    MEM_WAIT = 3'd3,
    DONE     = 3'd4
  } seq_state;

  localparam logic [15:0] kCycleMax = 16'hFFFF;

  // Increment that sticks at kCycleMax instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == kCycleMax) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/seq_ctrl_pc_unit.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pc_unit (pc_unit)
// Holds the program counter and computes its next value: clear to zero,
// increment, or add a sign-extended relative offset. All arithmetic wraps
// modulo 2^PC_W.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          load PC with 0 (program start)
//   adv_i          advance the PC this cycle
//   br_i           when advancing, add ofs_i instead of 1
//   ofs_i          signed PC-relative offset
//   pc_o           current PC
// -----------------------------------------------------------------------------
module seq_ctrl_pc_unit #(
  parameter int PC_W  = 10,
  parameter int OFS_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic             br_i,
  input  logic [OFS_W-1:0] ofs_i,
  output logic [PC_W-1:0]  pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] ofs_ext;

  // Sign extension; negative offsets wrap naturally in the PC_W-bit add.
  assign ofs_ext = {{(PC_W-OFS_W){ofs_i[OFS_W-1]}}, ofs_i};

  // Next-PC selection.
  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (adv_i) begin
      if (br_i) begin
        pc_d = pc_q + ofs_ext;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/seq_ctrl.sv
// -----------------------------------------------------------------------------
// seq_ctrl
// Multi-cycle instruction sequencer. Steps each instruction through FETCH and
// EXEC, plus a MEM_WAIT handshake for loads/stores, and turns the level-valued
// decode signals into single-cycle commit strobes.
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   Start               begin a program at PC 0 (only from IDLE or DONE)
//   RegWrite, MemWrite, LdStSel, BranchRel, Halt   decode of current instr
//   BranchTaken, BranchOfs                         branch condition/offset
//   MemAck              data memory completed the request
//   PC                  instruction ROM address
//   InstrValid          high in EXEC
//   RegWriteEn          register file write strobe
//   MemWriteEn, MemReq  data memory write enable / request
//   Done, Error         program finished / sticky memory timeout
//   CycleCount          busy cycles since Start, saturating
// -----------------------------------------------------------------------------
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int OFS_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             RegWrite,
  input  logic             MemWrite,
  input  logic             LdStSel,
  input  logic             BranchRel,
  input  logic             Halt,
  input  logic             BranchTaken,
  input  logic [OFS_W-1:0] BranchOfs,
  input  logic             MemAck,
  output logic [PC_W-1:0]  PC,
  output logic             InstrValid,
  output logic             RegWriteEn,
  output logic             MemWriteEn,
  output logic             MemReq,
  output logic             Done,
  output logic             Error,
  output logic [15:0]      CycleCount
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Value the wait counter holds in the last permitted MEM_WAIT cycle.
  localparam logic [WAIT_W-1:0] kWaitLast = WAIT_W'(TIMEOUT - 1);

  seq_state          state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [15:0]       cyc_q, cyc_d;
  logic              err_q, err_d;

  logic pc_clr_s, pc_adv_s, pc_br_s, cyc_clr_s;
  logic iv_s, rwe_s, mwe_s, mreq_s;
  logic mem_op_s;

  assign mem_op_s = MemWrite | (LdStSel & RegWrite);

  // Next-state and combinational output decode.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    err_d     = err_q;
    pc_clr_s  = 1'b0;
    pc_adv_s  = 1'b0;
    pc_br_s   = 1'b0;
    cyc_clr_s = 1'b0;
    iv_s      = 1'b0;
    rwe_s     = 1'b0;
    mwe_s     = 1'b0;
    mreq_s    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          pc_clr_s  = 1'b1;
          cyc_clr_s = 1'b1;
          err_d     = 1'b0;
          state_d   = FETCH;
        end else begin
          state_d = state_q;
        end
      end
      FETCH: begin
        state_d = EXEC;
      end
      EXEC: begin
        iv_s = 1'b1;
        if (Halt) begin
          state_d = DONE;
        end else if (mem_op_s) begin
          wait_d  = '0;
          state_d = MEM_WAIT;
        end else begin
          rwe_s    = RegWrite;
          pc_adv_s = 1'b1;
          pc_br_s  = BranchRel & BranchTaken;
          state_d  = FETCH;
        end
      end
      MEM_WAIT: begin
        mreq_s = 1'b1;
        mwe_s  = MemWrite;
        // An ack in the final permitted cycle still wins over the timeout.
        if (MemAck) begin
          rwe_s    = LdStSel;
          pc_adv_s = 1'b1;
          state_d  = FETCH;
        end else if (wait_q == kWaitLast) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Cycle counter next value: counts only busy states.
  always_comb begin
    cyc_d = cyc_q;
    if (cyc_clr_s) begin
      cyc_d = '0;
    end else if ((state_q == FETCH) || (state_q == EXEC) || (state_q == MEM_WAIT)) begin
      cyc_d = sat_inc16(cyc_q);
    end else begin
      cyc_d = cyc_q;
    end
  end

  // State, wait counter, cycle counter and error flag registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  seq_ctrl_pc_unit #(
    .PC_W  (PC_W),
    .OFS_W (OFS_W)
  ) u_pc_unit (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .clr_i  (pc_clr_s),
    .adv_i  (pc_adv_s),
    .br_i   (pc_br_s),
    .ofs_i  (BranchOfs),
    .pc_o   (PC)
  );

  assign InstrValid = iv_s;
  assign RegWriteEn = rwe_s;
  assign MemWriteEn = mwe_s;
  assign MemReq     = mreq_s;
  assign Done       = (state_q == DONE);
  assign Error      = err_q;
  assign CycleCount = cyc_q;

endmodule

// File: tb/tb_seq_ctrl.sv
module tb_seq_ctrl;

  localparam int PC_W    = 10;
  localparam int OFS_W   = 8;
  localparam int TIMEOUT = 15;
  localparam int PC_MASK = (1 << PC_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Start;
  logic             RegWrite, MemWrite, LdStSel, BranchRel, Halt, BranchTaken;
  logic [OFS_W-1:0] BranchOfs;
  logic             MemAck;
  logic [PC_W-1:0]  PC;
  logic             InstrValid, RegWriteEn, MemWriteEn, MemReq, Done, Error;
  logic [15:0]      CycleCount;

  seq_ctrl #(.PC_W(PC_W), .OFS_W(OFS_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .LdStSel(LdStSel),
    .BranchRel(BranchRel), .Halt(Halt), .BranchTaken(BranchTaken),
    .BranchOfs(BranchOfs), .MemAck(MemAck), .PC(PC),
    .InstrValid(InstrValid), .RegWriteEn(RegWriteEn), .MemWriteEn(MemWriteEn),
    .MemReq(MemReq), .Done(Done), .Error(Error), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  // Pulse counters used for "exactly N strobes" checks.
  int rwe_cnt = 0;
  int mreq_cnt = 0;
  int mwe_cnt = 0;
  always @(posedge Clk) begin
    rwe_cnt  <= rwe_cnt + (RegWriteEn ? 1 : 0);
    mreq_cnt <= mreq_cnt + (MemReq ? 1 : 0);
    mwe_cnt  <= mwe_cnt + (MemWriteEn ? 1 : 0);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: program counter, busy cycles, sticky error.
  int mpc, mcyc;
  bit merr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic rw, input logic mw, input logic ls, input logic br,
                         input logic ht, input logic tk, input logic [OFS_W-1:0] ofs);
    RegWrite = rw; MemWrite = mw; LdStSel = ls; BranchRel = br;
    Halt = ht; BranchTaken = tk; BranchOfs = ofs;
  endtask

  task automatic start_prog();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    mpc = 0; mcyc = 0; merr = 1'b0;
    chk("start_cyc", 32'(CycleCount), 32'd0);
    chk("start_err", 32'(Error), 32'd0);
    chk("start_pc", 32'(PC), 32'd0);
  endtask

  // Runs one instruction from its FETCH cycle; fin=1 when DONE follows.
  // noise holds Start high and jitters MemAck outside MEM_WAIT (both ignored).
  task automatic run_instr(input logic rw, input logic mw, input logic ls, input logic br,
                           input logic ht, input logic tk, input logic [OFS_W-1:0] ofs,
                           input int delay, input bit noise, output bit fin);
    bit mem;
    mem = !ht && (mw || (ls && rw));
    fin = 1'b0;
    // FETCH: decode bus carries junk
    set_dec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            OFS_W'($urandom));
    Start  = noise;
    MemAck = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge Clk);
    chk("fetch_pc", 32'(PC), 32'(mpc));
    chk("fetch_iv", 32'(InstrValid), 32'd0);
    chk("fetch_rwe", 32'(RegWriteEn), 32'd0);
    chk("fetch_mreq", 32'(MemReq), 32'd0);
    @(posedge Clk); #1;
    // EXEC
    set_dec(rw, mw, ls, br, ht, tk, ofs);
    MemAck = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge Clk);
    chk("exec_iv", 32'(InstrValid), 32'd1);
    chk("exec_pc", 32'(PC), 32'(mpc));
    chk("exec_rwe", 32'(RegWriteEn), 32'(!ht && !mem && rw));
    chk("exec_mreq", 32'(MemReq), 32'd0);
    chk("exec_mwe", 32'(MemWriteEn), 32'd0);
    @(posedge Clk); #1;
    mcyc += 2;
    if (ht) begin
      fin = 1'b1;
    end else if (!mem) begin
      if (br && tk) mpc = (mpc + int'($signed(ofs))) & PC_MASK;
      else          mpc = (mpc + 1) & PC_MASK;
    end else begin
      for (int w = 0; w < TIMEOUT; w++) begin
        MemAck = (w == delay);
        @(negedge Clk);
        chk("mw_req", 32'(MemReq), 32'd1);
        chk("mw_we", 32'(MemWriteEn), 32'(mw));
        chk("mw_rwe", 32'(RegWriteEn), 32'((w == delay) ? ls : 1'b0));
        chk("mw_iv", 32'(InstrValid), 32'd0);
        chk("mw_pc", 32'(PC), 32'(mpc));
        @(posedge Clk); #1;
        mcyc++;
        if (w == delay) begin
          mpc = (mpc + 1) & PC_MASK;
          break;
        end
        if (w == TIMEOUT - 1) begin
          merr = 1'b1;
          fin  = 1'b1;
        end
      end
    end
    Start  = 1'b0;
    MemAck = 1'b0;
  endtask

  task automatic check_done();
    @(negedge Clk);
    chk("done", 32'(Done), 32'd1);
    chk("done_err", 32'(Error), 32'(merr));
    chk("done_cyc", 32'(CycleCount), 32'(mcyc > 65535 ? 65535 : mcyc));
    chk("done_pc", 32'(PC), 32'(mpc));
    chk("done_mreq", 32'(MemReq), 32'd0);
    chk("done_rwe", 32'(RegWriteEn), 32'd0);
    @(posedge Clk); #1;
  endtask

  initial begin
    bit fin;
    int r0, q0, m0;
    Reset_n = 1'b0; Start = 1'b0; MemAck = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_err", 32'(Error), 32'd0);
    chk("rst_cyc", 32'(CycleCount), 32'd0);
    chk("rst_mreq", 32'(MemReq), 32'd0);
    chk("rst_iv", 32'(InstrValid), 32'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    chk("idle_done", 32'(Done), 32'd0);

    // ALU, ALU, Halt: two write strobes, six busy cycles
    start_prog();
    r0 = rwe_cnt;
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0, fin);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0, fin);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 0, 1'b0, fin);
    chk("alu_rwe_pulses", 32'(rwe_cnt - r0), 32'd2);
    check_done();
    chk("alu_cyc6", 32'(CycleCount), 32'd6);

    // Branch at PC 5, offset -3, taken then not taken
    for (int t = 0; t < 2; t++) begin
      start_prog();
      for (int i = 0; i < 5; i++)
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0, fin);
      run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'(t == 0), 8'hFD, 0, 1'b0, fin);
      chk("br5_target", 32'(mpc), (t == 0) ? 32'd2 : 32'd6);
      run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 0, 1'b0, fin);
      check_done();
    end

    // Wrap: 0 -1 -> 1023, then +2 -> 1
    start_prog();
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 1'b0, fin);
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 0, 1'b0, fin);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 0, 1'b0, fin);
    check_done();

    // Load acked after 3 waits, then load acked in the last permitted cycle
    start_prog();
    r0 = rwe_cnt; q0 = mreq_cnt; m0 = mwe_cnt;
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3, 1'b0, fin);
    chk("ld_mreq4", 32'(mreq_cnt - q0), 32'd4);
    chk("ld_rwe1", 32'(rwe_cnt - r0), 32'd1);
    chk("ld_mwe0", 32'(mwe_cnt - m0), 32'd0);
    run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, TIMEOUT - 1, 1'b1, fin);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 0, 1'b0, fin);
    check_done();

    // Store never acked, Start held high throughout: timeout into DONE
    start_prog();
    r0 = rwe_cnt; m0 = mwe_cnt;
    run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 99, 1'b1, fin);
    chk("st_fin", 32'(fin), 32'd1);
    chk("st_mwe15", 32'(mwe_cnt - m0), 32'(TIMEOUT));
    chk("st_rwe0", 32'(rwe_cnt - r0), 32'd0);
    check_done();

    // Restart from DONE clears Error and CycleCount
    start_prog();
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0, fin);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 0, 1'b0, fin);
    check_done();

    // Reset in the middle of MEM_WAIT
    start_prog();
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0, fin);
    set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge Clk); #1;          // now EXEC
    @(posedge Clk); #1;          // MEM_WAIT cycle 0
    @(negedge Clk);
    chk("rstmw_req_before", 32'(MemReq), 32'd1);
    chk("rstmw_pc_before", 32'(PC), 32'd1);
    @(posedge Clk); #2;          // MEM_WAIT cycle 1
    Reset_n = 1'b0;
    #1;
    chk("rstmw_mreq", 32'(MemReq), 32'd0);
    chk("rstmw_mwe", 32'(MemWriteEn), 32'd0);
    chk("rstmw_pc", 32'(PC), 32'd0);
    chk("rstmw_cyc", 32'(CycleCount), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge Clk); #1;
    chk("rstmw_idle_done", 32'(Done), 32'd0);
    chk("rstmw_idle_mreq", 32'(MemReq), 32'd0);

    // Random programs against the model
    for (int p = 0; p < 5; p++) begin
      start_prog();
      fin = 1'b0;
      for (int i = 0; i < 30 && !fin; i++) begin
        int kind, dly;
        logic rw, mw, ls, br, tk;
        logic [OFS_W-1:0] ofs;
        kind = $urandom_range(0, 9);
        rw = 1'($urandom_range(0, 1)); mw = 1'b0; ls = 1'b0; br = 1'b0;
        tk = 1'($urandom_range(0, 1)); ofs = OFS_W'($urandom);
        dly = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 16) : $urandom_range(0, 4);
        case (kind)
          4, 5:    br = 1'b1;
          6, 7:    begin rw = 1'b1; ls = 1'b1; end
          8:       begin mw = 1'b1; ls = 1'($urandom_range(0, 1)); end
          9:       begin ls = 1'b1; rw = 1'b0; br = 1'($urandom_range(0, 1)); end
          default: br = 1'b0;
        endcase
        run_instr(rw, mw, ls, br, 1'b0, tk, ofs, dly, 1'($urandom_range(0, 1)), fin);
      end
      if (!fin) run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                          1'b1, 1'b0, 8'd0, 0, 1'b0, fin);
      check_done();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
